fp_mult_result_monitor: RTL
===========================

Name: fp_mult_result_monitor

Overview:
Downstream consumer of the registered FP multiplier top. Each cycle it takes the DUT result (z, status) and the function-model result (z_function_out), together with the operands presented upstream, and aligns them internally. It compares the results, keeps saturating statistics, and buffers mismatching transactions in a FIFO that the bench or debug logic drains over a valid/ready port.

Parameters:
LAT, 2, cycles from operands at the top's a/b inputs to z/z_ref appearing at this block's inputs (operand delay-line depth, >=1)
DEPTH, 8, mismatch log entries (power of 2, >=2)
CNT_W, 16, width of every statistics counter
NAN_EQ, 1, 1: any-NaN z equals any-NaN z_ref; 0: bit-exact compare only

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of counters, log and delay line
in_valid  in  1  a/b carry a valid transaction this cycle (same cycle as the top's a/b)
a  in  32  operand A, as given to the top
b  in  32  operand B, as given to the top
z  in  32  DUT result
z_ref  in  32  function-model result
status  in  8  DUT status flags; [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] unused
log_valid  out  1  log head entry available
log_ready  in  1  consumer takes head entry
log_a  out  32  head entry operand A
log_b  out  32  head entry operand B
log_z  out  32  head entry DUT result
log_zref  out  32  head entry reference result
log_status  out  8  head entry status
log_count  out  $clog2(DEPTH)+1  entries held
log_overflow  out  1  sticky: a mismatch was dropped because the log was full
total_cnt  out  CNT_W  compared transactions
err_cnt  out  CNT_W  mismatches
nan_cnt  out  CNT_W  compared transactions with status[2]=1
inexact_cnt  out  CNT_W  compared transactions with status[5]=1
pass  out  1  err_cnt==0

Behaviour:
- Reset (rst=0, asynchronous): delay line valid bits 0; FIFO pointers 0; all counters 0; log_overflow=0; log_valid=0; log_count=0; log_* data 0; pass=1. clear=1 has the same effect, synchronously; clear takes priority over every other event in that cycle.
- Delay line: LAT-stage shift register of {in_valid, a, b}. Stage LAT output (cmp_valid, a_d, b_d) is aligned with z/z_ref/status in the same cycle. With LAT=2, operands at cycle t are compared against z/z_ref at cycle t+2.
- Compare, combinational on the aligned stage. match = (z==z_ref) OR (NAN_EQ and both are NaN: exp==8'hFF and mant!=0). Infinity is never treated as NaN.
- On cmp_valid (registered, visible next cycle):
  - total_cnt+1.
  - nan_cnt+1 if status[2]; inexact_cnt+1 if status[5].
  - If !match: err_cnt+1 and a log push of {a_d, b_d, z, z_ref, status}.
- All counters saturate at 2^CNT_W-1, with no wrap.
- FIFO, DEPTH entries, registered outputs from head:
  - Pop when log_valid && log_ready.
  - Push is accepted if log_count<DEPTH, or if log_count==DEPTH and a pop occurs in the same cycle. In that case the count stays DEPTH and the new entry goes to the tail.
  - A push refused for lack of space is dropped: log_overflow<=1 (sticky until reset/clear); err_cnt still increments.
  - Pop and push together when empty: not possible, since log_valid=0; the push lands and log_valid=1 the next cycle.
  - Pointers wrap modulo DEPTH; log_count updates the cycle after the push/pop.
- Latency from mismatch at the compare stage to log_valid (empty FIFO): 1 cycle. Counters update 1 cycle after the compare stage.
- log_* stable while log_valid && !log_ready.
- in_valid=0 cycles flow through the delay line and cause no compare. z/z_ref are ignored when cmp_valid=0.

Test Plan:
- Matching product: in_valid=1, a=3F800000, b=40000000; 2 cycles later z=z_ref=40000000, status=0 -> next cycle total_cnt=1, err_cnt=0, pass=1, log_valid=0.
- Mismatch logging: a=3FC00000, b=3FC00000, aligned z=40100001, z_ref=40100000, status=8'h20 -> err_cnt=1, inexact_cnt=1, pass=0, log_valid=1 with log_a=3FC00000, log_z=40100001, log_zref=40100000, log_status=20; pulse log_ready -> log_count=0.
- NaN equivalence: z=7FC00000, z_ref=7FC00001, status=8'h04. With NAN_EQ=1 -> err_cnt unchanged, nan_cnt=1. With NAN_EQ=0 -> err_cnt=1. Also z=7F800000 vs z_ref=7FC00000 -> mismatch for either NAN_EQ.
- Overflow: DEPTH=8, log_ready=0, 9 consecutive mismatches -> log_count=8, log_overflow=1, err_cnt=9. Then one cycle with log_ready=1 plus a mismatch -> log_count stays 8, head becomes entry 2, tail holds the new entry.
- Saturation: CNT_W=4, 20 matching transactions -> total_cnt=15, err_cnt=0.
- Reset/clear mid-stream: 3 transactions in flight, assert rst=0 asynchronously mid-cycle -> all outputs to reset values immediately, and no compare for in-flight operands after release. Repeat with clear=1 -> same result on the next edge.

Source files
------------

// File: rtl/fp_mult_result_monitor.sv
// fp_mult_result_monitor: checks the FP multiplier's registered result
// against the function-model result. Operands are delayed until they line up
// with z/z_ref. The block keeps saturating statistics and logs mismatching
// transactions into a small FIFO that is drained over a valid/ready port.
module fp_mult_result_monitor #(
    parameter int LAT    = 2,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    parameter int NAN_EQ = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [31:0]              a,
    input  logic [31:0]              b,
    input  logic [31:0]              z,
    input  logic [31:0]              z_ref,
    input  logic [7:0]               status,
    output logic                     log_valid,
    input  logic                     log_ready,
    output logic [31:0]              log_a,
    output logic [31:0]              log_b,
    output logic [31:0]              log_z,
    output logic [31:0]              log_zref,
    output logic [7:0]               log_status,
    output logic [$clog2(DEPTH):0]   log_count,
    output logic                     log_overflow,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         nan_cnt,
    output logic [CNT_W-1:0]         inexact_cnt,
    output logic                     pass
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [31:0] zref;
        logic [7:0]  status;
    } log_t;

    // ---------------- operand delay line ----------------
    logic [LAT:1]       vld_pipe;
    logic [LAT:1][31:0] a_pipe;
    logic [LAT:1][31:0] b_pipe;

    // Shift {in_valid, a, b} LAT stages so they meet z/z_ref
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else if (clear) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            a_pipe[1]   <= a;
            b_pipe[1]   <= b;
            for (int i = LAT; i > 1; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
        end
    end

    // ---------------- compare stage ----------------
    function automatic logic is_nan(input logic [31:0] v);
        return (&v[30:23]) && (|v[22:0]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic cmp_valid, match, mismatch;
    log_t new_ent;

    // Result equality; NaN payloads are ignored when NAN_EQ is set (Inf is not NaN)
    always_comb begin
        cmp_valid      = vld_pipe[LAT];
        match          = (z == z_ref) || ((NAN_EQ != 0) && is_nan(z) && is_nan(z_ref));
        mismatch       = cmp_valid && !match;
        new_ent.a      = a_pipe[LAT];
        new_ent.b      = b_pipe[LAT];
        new_ent.z      = z;
        new_ent.zref   = z_ref;
        new_ent.status = status;
    end

    // ---------------- statistics ----------------
    // Saturating counters, updated the cycle after the compare stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_cnt   <= '0;
            err_cnt     <= '0;
            nan_cnt     <= '0;
            inexact_cnt <= '0;
        end else if (clear) begin
            total_cnt   <= '0;
            err_cnt     <= '0;
            nan_cnt     <= '0;
            inexact_cnt <= '0;
        end else if (cmp_valid) begin
            total_cnt <= sat_inc(total_cnt);
            if (status[2]) nan_cnt     <= sat_inc(nan_cnt);
            if (status[5]) inexact_cnt <= sat_inc(inexact_cnt);
            if (!match)    err_cnt     <= sat_inc(err_cnt);
        end
    end

    assign pass = (err_cnt == '0);

    // ---------------- mismatch log FIFO ----------------
    log_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          full, pop, push, drop;

    // When full, a same-cycle pop frees the head slot, which is also the
    // write slot, so the new entry becomes the tail after rd_ptr advances.
    always_comb begin
        full = (cnt == FULL_CNT);
        pop  = log_valid && log_ready;
        push = mismatch && (!full || pop);
        drop = mismatch && full && !pop;
    end

    // Storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            log_overflow <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_ent;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (drop) log_overflow <= 1'b1;
        end
    end

    // Head entry straight from storage; data is zero after reset/clear
    always_comb begin
        log_valid  = (cnt != '0);
        log_count  = cnt;
        log_a      = mem[rd_ptr].a;
        log_b      = mem[rd_ptr].b;
        log_z      = mem[rd_ptr].z;
        log_zref   = mem[rd_ptr].zref;
        log_status = mem[rd_ptr].status;
    end

endmodule
